p_uart_send: RTL and testbench

Packet UART transmitter; the transmit-side counterpart of the 8-byte packet receiver.
- Accepts one 64-bit word on a start request.
- Serialises it as eight consecutive 8N1 UART frames, LSB byte first (byte 0 = uart_din[7:0]).
- Uses an internal byte-level transmitter.
- Sits between host/test logic and the board uart_txd pin. It mirrors the receiver's byte ordering, so a loopback reassembles the identical word.

---
 rtl/p_uart_send_pkg.sv | 19 +
 rtl/uart_send.sv | 82 ++++++++
 rtl/p_uart_send.sv | 129 ++++++++++++
 tb/tb_p_uart_send.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/p_uart_send_pkg.sv
// Shared constants, FSM encodings and baud divider helper for the packet UART transmitter.
package p_uart_send_pkg;

  localparam int unsigned PktBytes  = 8;
  localparam int unsigned ByteW     = 8;
  localparam int unsigned FrameBits = 10;

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StLoad = 3'd1;
  localparam logic [2:0] StWait = 3'd2;
  localparam logic [2:0] StGap  = 3'd3;
  localparam logic [2:0] StDone = 3'd4;

  function automatic int unsigned calc_bps_cnt(input int unsigned clk_freq,
                                               input int unsigned uart_bps);
    return clk_freq / uart_bps;
  endfunction

endpackage

// File: rtl/uart_send.sv
// Byte-level 8N1 transmitter: latches byte_data on byte_en, then shifts start/data/stop bits.
module uart_send
  import p_uart_send_pkg::*;
#(
  parameter int unsigned BPS_CNT = 5208
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             byte_en,
  input  logic [ByteW-1:0] byte_data,
  output logic             uart_txd,
  output logic             byte_busy,
  output logic             byte_done
);

  localparam logic [15:0] BitEnd  = 16'(BPS_CNT - 1);
  localparam logic [3:0]  StopIdx = 4'(FrameBits - 1);

  logic             tx_flag_q, tx_flag_d;
  logic [ByteW-1:0] data_q, data_d;
  logic [15:0]      clk_cnt_q, clk_cnt_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic             txd_q, txd_d;
  logic             stop_q;
  logic             bit_end, frame_end;
  logic [9:0]       frame;

  always_comb begin
    frame     = {1'b1, data_q, 1'b0};
    bit_end   = (clk_cnt_q == BitEnd);
    frame_end = tx_flag_q && bit_end && (bit_cnt_q == StopIdx);

    tx_flag_d = tx_flag_q;
    data_d    = data_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    if (!tx_flag_q) begin
      if (byte_en) begin
        tx_flag_d = 1'b1;
        data_d    = byte_data;
        clk_cnt_d = '0;
        bit_cnt_d = '0;
      end
    end else if (bit_end) begin
      clk_cnt_d = '0;
      if (frame_end) begin
        tx_flag_d = 1'b0;
      end else begin
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else begin
      clk_cnt_d = clk_cnt_q + 16'd1;
    end

    // Line is registered, so it trails the counters by one clock.
    txd_d = tx_flag_q ? frame[bit_cnt_q] : 1'b1;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tx_flag_q <= 1'b0;
      data_q    <= '0;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      txd_q     <= 1'b1;
      stop_q    <= 1'b0;
    end else begin
      tx_flag_q <= tx_flag_d;
      data_q    <= data_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      txd_q     <= txd_d;
      stop_q    <= frame_end;
    end
  end

  assign uart_txd  = txd_q;
  assign byte_done = frame_end;
  // Busy also covers the final stop-bit clock still on the wire.
  assign byte_busy = tx_flag_q | stop_q;

endmodule

// File: rtl/p_uart_send.sv
// Packet UART transmitter: sends a 64-bit word as eight 8N1 frames, LSB byte first.
// Define P_UART_SEND_GAP_EN to insert GAP_BITS idle bit-times between bytes.
module p_uart_send
  import p_uart_send_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned UART_BPS = 9600,
  parameter int unsigned GAP_BITS = 1
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        uart_en,
  input  logic [63:0] uart_din,
  output logic        uart_txd,
  output logic        tx_busy,
  output logic [3:0]  tx_cnt,
  output logic        uart_done
);

  localparam int unsigned BPS_CNT = calc_bps_cnt(CLK_FREQ, UART_BPS);
  localparam logic [3:0]  CntFull = 4'(PktBytes);

  logic        en_d0_q, en_d1_q;
  logic        start_flag;
  logic [2:0]  state_q, state_d;
  logic [63:0] shreg_q, shreg_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        byte_en_q, byte_en_d;
  logic        byte_busy, byte_done;

`ifdef P_UART_SEND_GAP_EN
  localparam logic [31:0] GapEnd = 32'(GAP_BITS * BPS_CNT - 1);
  logic [31:0] gap_cnt_q, gap_cnt_d;
`endif

  assign start_flag = en_d0_q & ~en_d1_q;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    byte_en_d = (state_q == StLoad);
`ifdef P_UART_SEND_GAP_EN
    gap_cnt_d = gap_cnt_q;
`endif
    case (state_q)
      StIdle: begin
        if (start_flag) begin
          shreg_d = uart_din;
          cnt_d   = '0;
          state_d = StLoad;
        end
      end
      StLoad: state_d = StWait;
      StWait: begin
        if (byte_done) begin
          cnt_d   = cnt_q + 4'd1;
          shreg_d = shreg_q >> ByteW;
          if (cnt_q != CntFull - 4'd1) begin
`ifdef P_UART_SEND_GAP_EN
            gap_cnt_d = '0;
            state_d   = StGap;
`else
            state_d = StLoad;
`endif
          end
        end else if (cnt_q == CntFull && !byte_busy) begin
          // Last byte: finish only once its stop bit has left the pin.
          state_d = StDone;
        end
      end
`ifdef P_UART_SEND_GAP_EN
      StGap: begin
        if (gap_cnt_q == GapEnd) begin
          state_d = StLoad;
        end else begin
          gap_cnt_d = gap_cnt_q + 32'd1;
        end
      end
`endif
      StDone: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      en_d0_q   <= 1'b0;
      en_d1_q   <= 1'b0;
      state_q   <= StIdle;
      shreg_q   <= '0;
      cnt_q     <= '0;
      byte_en_q <= 1'b0;
`ifdef P_UART_SEND_GAP_EN
      gap_cnt_q <= '0;
`endif
    end else begin
      en_d0_q   <= uart_en;
      en_d1_q   <= en_d0_q;
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      byte_en_q <= byte_en_d;
`ifdef P_UART_SEND_GAP_EN
      gap_cnt_q <= gap_cnt_d;
`endif
    end
  end

  uart_send #(
    .BPS_CNT (BPS_CNT)
  ) u_uart_send (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .byte_en   (byte_en_q),
    .byte_data (shreg_q[ByteW-1:0]),
    .uart_txd  (uart_txd),
    .byte_busy (byte_busy),
    .byte_done (byte_done)
  );

  assign tx_busy   = (state_q != StIdle);
  assign uart_done = (state_q == StDone);
  assign tx_cnt    = cnt_q;

endmodule

// File: tb/tb_p_uart_send.sv
// Bench for p_uart_send: decodes the serial line and checks bytes and timing against a timing model.
module tb_p_uart_send;

  localparam int unsigned ClkFreq = 1000000;
  localparam int unsigned UartBps = 100000;
  localparam int unsigned GapBits = 2;
  localparam int B = ClkFreq / UartBps;
`ifdef P_UART_SEND_GAP_EN
  localparam int G = GapBits * B;
`else
  localparam int G = 0;
`endif
  localparam int IdleClk  = 2 + G;
  localparam int Spacing  = 10 * B + IdleClk;
  localparam int DoneOff  = 80 * B + 7 * IdleClk + 1;
  localparam int StartLat = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        uart_en;
  logic [63:0] uart_din;
  logic        txd;
  logic        tx_busy;
  logic [3:0]  tx_cnt;
  logic        uart_done;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [7:0] rx_bytes[$];
  int         start_cyc[$];
  int         start_cnt[$];
  int         done_cyc[$];
  int         done_cnt[$];
  int         busy_fall[$];
  int         frame_err;
  int         cnt_viol;

  p_uart_send #(
    .CLK_FREQ (ClkFreq),
    .UART_BPS (UartBps),
    .GAP_BITS (GapBits)
  ) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .uart_en   (uart_en),
    .uart_din  (uart_din),
    .uart_txd  (txd),
    .tx_busy   (tx_busy),
    .tx_cnt    (tx_cnt),
    .uart_done (uart_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  task automatic clear_mon();
    rx_bytes.delete();
    start_cyc.delete();
    start_cnt.delete();
    done_cyc.delete();
    done_cnt.delete();
    busy_fall.delete();
    frame_err = 0;
    cnt_viol  = 0;
  endtask

  // Line decoder acting as the receiver: samples each bit at its centre.
  initial begin : monitor
    bit         in_frame = 1'b0;
    logic       prev_txd = 1'b1;
    logic       prev_busy = 1'b0;
    logic [3:0] prev_cnt = '0;
    logic [7:0] sh = '0;
    int         fstart = 0;
    int         off, bi;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_frame  = 1'b0;
        prev_txd  = 1'b1;
        prev_busy = 1'b0;
        prev_cnt  = '0;
      end else begin
        if (!in_frame && prev_txd && !txd) begin
          in_frame = 1'b1;
          fstart   = cyc;
          sh       = '0;
          start_cyc.push_back(cyc);
          start_cnt.push_back(int'(tx_cnt));
        end
        if (in_frame) begin
          off = cyc - fstart;
          if (off % B == B / 2) begin
            bi = off / B;
            if (bi == 0) begin
              if (txd !== 1'b0) frame_err++;
            end else if (bi <= 8) begin
              sh[bi-1] = txd;
            end else begin
              if (txd !== 1'b1) frame_err++;
              rx_bytes.push_back(sh);
              in_frame = 1'b0;
            end
          end
        end
        if (uart_done) begin
          done_cyc.push_back(cyc);
          done_cnt.push_back(int'(tx_cnt));
        end
        if (prev_busy && !tx_busy) busy_fall.push_back(cyc);
        if (tx_cnt != prev_cnt && !(tx_cnt == prev_cnt + 4'd1 || (tx_cnt == 0 && prev_cnt == 8)))
          cnt_viol++;
        if (tx_cnt > 4'd8) cnt_viol++;
        prev_txd  = txd;
        prev_busy = tx_busy;
        prev_cnt  = tx_cnt;
      end
    end
  end

  // mode 0: plain request; 1: second request mid-packet; 2: request edge during uart_done.
  task automatic send_packet(input logic [63:0] word, input int hold, input int mode,
                             input string tag);
    int          r;
    int          t_done;
    bit          seen;
    logic [63:0] rx_word;
    clear_mon();
    @(negedge clk);
    uart_din = word;
    uart_en  = 1'b1;
    r        = cyc + 1;
    t_done   = r + StartLat + DoneOff;
    repeat (hold) @(negedge clk);
    uart_en = 1'b0;
    if (mode == 1) begin
      repeat (3 * Spacing) @(negedge clk);
      uart_din = '1;
      uart_en  = 1'b1;
      @(negedge clk);
      uart_en = 1'b0;
    end else if (mode == 2) begin
      while (cyc < t_done - 1) @(negedge clk);
      uart_en = 1'b1;
      @(negedge clk);
      uart_en = 1'b0;
    end
    seen = 1'b0;
    for (int i = 0; i < DoneOff + Spacing && !seen; i++) begin
      if (done_cyc.size() > 0) seen = 1'b1;
      else @(negedge clk);
    end
    repeat (40) @(negedge clk);

    check_eq({tag, ".done_seen"}, seen, 1);
    check_eq({tag, ".nbytes"}, rx_bytes.size(), 8);
    rx_word = '0;
    for (int k = 0; k < 8; k++) begin
      if (k < rx_bytes.size()) begin
        check_eq($sformatf("%s.b%0d.data", tag, k), rx_bytes[k], word[8*k+:8]);
        rx_word[8*k+:8] = rx_bytes[k];
      end
      if (k < start_cyc.size()) begin
        check_eq($sformatf("%s.b%0d.start", tag, k), start_cyc[k], r + StartLat + k * Spacing);
        check_eq($sformatf("%s.b%0d.cnt", tag, k), start_cnt[k], k);
      end
    end
    check_eq({tag, ".word"}, rx_word, word);
    check_eq({tag, ".ndone"}, done_cyc.size(), 1);
    if (done_cyc.size() > 0) begin
      check_eq({tag, ".done_at"}, done_cyc[0], t_done);
      check_eq({tag, ".cnt_at_done"}, done_cnt[0], 8);
    end
    check_eq({tag, ".nfall"}, busy_fall.size(), 1);
    if (busy_fall.size() > 0) check_eq({tag, ".busy_fall_at"}, busy_fall[0], t_done + 1);
    check_eq({tag, ".frame_err"}, frame_err, 0);
    check_eq({tag, ".cnt_steps"}, cnt_viol, 0);
    check_eq({tag, ".cnt_idle"}, tx_cnt, 0);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [63:0] w;
    uart_en  = 1'b0;
    uart_din = '0;
    rst_n    = 1'b0;
    clear_mon();
    repeat (3) @(negedge clk);
    check_eq("rst.txd", txd, 1);
    check_eq("rst.busy", tx_busy, 0);
    check_eq("rst.cnt", tx_cnt, 0);
    check_eq("rst.done", uart_done, 0);
    #3 rst_n = 1'b1;
    repeat (5) @(negedge clk);

    send_packet(64'h0807060504030201, 1, 0, "seq");
    send_packet(rand64(), 2000, 0, "hold");
    send_packet(rand64(), 1, 1, "inject");
    send_packet(rand64(), 1, 2, "done_edge");

    // Reset in the middle of byte 3.
    clear_mon();
    @(negedge clk);
    uart_din = rand64();
    uart_en  = 1'b1;
    @(negedge clk);
    uart_en = 1'b0;
    for (int i = 0; i < 5 * Spacing && start_cyc.size() < 4; i++) @(negedge clk);
    check_eq("midrst.reached_b3", start_cyc.size() >= 4, 1);
    repeat (3 * B) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_eq("midrst.txd", txd, 1);
    check_eq("midrst.busy", tx_busy, 0);
    check_eq("midrst.cnt", tx_cnt, 0);
    check_eq("midrst.done", uart_done, 0);
    @(negedge clk);
    #3 rst_n = 1'b1;
    clear_mon();
    repeat (60) @(negedge clk);
    check_eq("midrst.no_resume", start_cyc.size(), 0);
    check_eq("midrst.idle_busy", tx_busy, 0);
    send_packet(rand64(), 1, 0, "after_rst");

    send_packet(64'hDEADBEEF_CAFEF00D, 1, 0, "loop");
    for (int i = 0; i < 3; i++) begin
      w = rand64();
      send_packet(w, int'($urandom_range(1, 6)), 0, $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
